// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage of the RISC-V pipeline.
// Non-memory ops pass straight through to WB. Aligned loads and stores run
// a single-outstanding req/ack bus transaction while the pipeline is
// stalled. The stage also steers byte lanes, sign/zero-extends load data,
// flags misaligned accesses and abandons accesses that are never acked.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   wd_i/wreg_i      destination register and write enable from EX/MEM
//   wdata_i          EX result; effective address for memory ops
//   aluop_i          operation code
//   reg2_i           store data (rs2)
//   mem_rdata_i      bus read data, valid with mem_ack_i
//   mem_ack_i        bus acknowledge, one-cycle pulse
//   mem_req_o        bus request (registered)
//   mem_we_o         bus write enable (registered)
//   mem_addr_o       word-aligned bus address (registered)
//   mem_sel_o        byte-lane enables, bit n = byte n (registered)
//   mem_wdata_o      lane-replicated store data (registered)
//   wd_o/wreg_o      destination register and write enable to WB
//   wdata_o          write data to WB
//   stallreq_o       stall request to the pipeline controller
//   misalign_o       misaligned access detected this cycle
//   bus_err_o        access timed out; one-cycle pulse (registered)
module mem_lsu #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_wdata_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_ld_data;
  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [3:0]       r_sel;
  logic [31:0]      r_wdata;
  logic             r_bus_err;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_is_mem;
  logic        w_misalign;
  logic [3:0]  w_sel;
  logic [31:0] w_st_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_fmt;
  logic        w_issue;
  logic        w_ack_take;
  logic        w_timeout;

  // Opcode decode: direction and access size.
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_is_byte  = 1'b0;
    w_is_half  = 1'b0;
    w_is_word  = 1'b0;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP: begin w_is_load  = 1'b1; w_is_byte = 1'b1; end
      EXE_LH_OP, EXE_LHU_OP: begin w_is_load  = 1'b1; w_is_half = 1'b1; end
      EXE_LW_OP:             begin w_is_load  = 1'b1; w_is_word = 1'b1; end
      EXE_SB_OP:             begin w_is_store = 1'b1; w_is_byte = 1'b1; end
      EXE_SH_OP:             begin w_is_store = 1'b1; w_is_half = 1'b1; end
      EXE_SW_OP:             begin w_is_store = 1'b1; w_is_word = 1'b1; end
      default: ;
    endcase
  end

  assign w_is_mem   = w_is_load | w_is_store;
  assign w_misalign = (w_is_half & wdata_i[0]) | (w_is_word & (wdata_i[1:0] != 2'b00));

  // Byte-lane enables and replicated store data; loads use the same lanes.
  always_comb begin
    w_sel     = 4'b0000;
    w_st_data = reg2_i;
    if (w_is_byte) begin
      w_sel     = 4'b0001 << wdata_i[1:0];
      w_st_data = {4{reg2_i[7:0]}};
    end else if (w_is_half) begin
      w_sel     = wdata_i[1] ? 4'b1100 : 4'b0011;
      w_st_data = {2{reg2_i[15:0]}};
    end else if (w_is_word) begin
      w_sel     = 4'b1111;
    end
  end

  // Load lane extraction and extension.
  assign w_byte = mem_rdata_i[{wdata_i[1:0], 3'b000} +: 8];
  assign w_half = wdata_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    w_ld_fmt = 32'h0;
    case (aluop_i)
      EXE_LB_OP:  w_ld_fmt = {{24{w_byte[7]}}, w_byte};
      EXE_LBU_OP: w_ld_fmt = {24'h0, w_byte};
      EXE_LH_OP:  w_ld_fmt = {{16{w_half[15]}}, w_half};
      EXE_LHU_OP: w_ld_fmt = {16'h0, w_half};
      EXE_LW_OP:  w_ld_fmt = mem_rdata_i;
      default:    w_ld_fmt = 32'h0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next state; ack takes priority over timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_ack_take  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_mem && !w_misalign) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          w_ack_take  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus registers, timeout counter, captured load data and error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_ld_data <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_sel     <= '0;
      r_wdata   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_issue) begin
        r_cnt   <= '0;
        r_req   <= 1'b1;
        r_we    <= w_is_store;
        r_addr  <= {wdata_i[31:2], 2'b00};
        r_sel   <= w_sel;
        r_wdata <= w_st_data;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_ack_take) begin
        r_ld_data <= w_ld_fmt;
      end
      if (w_ack_take || w_timeout) begin
        r_req <= 1'b0;
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end else if (r_state == S_DONE) begin
        r_bus_err <= 1'b0;
      end
    end
  end

  // WB-side outputs and stall; all forced low while reset is held.
  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_mem) begin
          wreg_o = 1'b0;
          if (w_misalign) misalign_o = 1'b1;
          else            stallreq_o = 1'b1;
        end
      end
      S_WAIT: begin
        wreg_o     = 1'b0;
        stallreq_o = 1'b1;
      end
      S_DONE: begin
        wdata_o = r_ld_data;
        wreg_o  = w_is_load & wreg_i & ~r_bus_err;
      end
      default: ;
    endcase
    if (!rst) begin
      wd_o       = 5'h0;
      wreg_o     = 1'b0;
      wdata_o    = 32'h0;
      stallreq_o = 1'b0;
      misalign_o = 1'b0;
    end
  end

  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_sel_o   = r_sel;
  assign mem_wdata_o = r_wdata;
  assign bus_err_o   = r_bus_err;

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: directed scenarios plus randomized back-to-back ops
// checked against a size/offset arithmetic reference model.
module tb_mem_lsu;

  localparam int unsigned TMO = 4;

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_NOP = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg2_i;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_wdata_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic        misalign_o;
  logic        bus_err_o;

  int total = 0;
  int bad   = 0;

  // Observations gathered by run_op for one instruction.
  int          obs_stall, obs_req;
  logic        obs_unstable, obs_hung, obs_misal, obs_req_start, obs_err_start;
  logic        obs_we;
  logic [31:0] obs_addr, obs_bwdata;
  logic [3:0]  obs_sel;
  logic        obs_wreg, obs_err, obs_done_req;
  logic [31:0] obs_wdata;
  logic [4:0]  obs_wd;

  mem_lsu #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .aluop_i(aluop_i), .reg2_i(reg2_i), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [7:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    if (op == OP_LW || op == OP_SW) return 4;
    return 0;
  endfunction

  function automatic bit m_is_load(input logic [7:0] op);
    return (op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW);
  endfunction

  function automatic bit m_misal(input logic [7:0] op, input logic [31:0] a);
    int sz;
    sz = m_size(op);
    return (sz != 0) && ((a % sz) != 0);
  endfunction

  function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
    int sz;
    int off;
    sz  = m_size(op);
    off = int'(a % 4);
    if (sz == 4) return 4'hF;
    if (sz == 2) return (off >= 2) ? 4'hC : 4'h3;
    return 4'(1 << off);
  endfunction

  function automatic logic [31:0] m_st(input logic [7:0] op, input logic [31:0] rs2);
    int sz;
    sz = m_size(op);
    if (sz == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] m_ld(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int          off;
    off = int'(a % 4);
    if (m_size(op) == 4) return rd;
    if (m_size(op) == 1) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (op == OP_LB && v >= 32'h80) v = v - 32'd256;
    end else begin
      v = (off >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
      if (op == OP_LH && v >= 32'h8000) v = v - 32'd65536;
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  // Applies one instruction in IDLE, acks `delay` cycles into WAIT
  // (delay >= TMO means never acked in time) and records what it sees.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rs2,
                        input logic [4:0] wd, input logic wr, input int delay,
                        input logic [31:0] rd);
    bit first;
    aluop_i = op; wdata_i = a; reg2_i = rs2; wd_i = wd; wreg_i = wr; mem_ack_i = 1'b0;
    obs_stall = 0; obs_req = 0; obs_unstable = 1'b0; obs_hung = 1'b1; first = 1'b1;
    obs_we = 1'b0; obs_addr = '0; obs_sel = '0; obs_bwdata = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) begin
        obs_misal = misalign_o; obs_req_start = mem_req_o; obs_err_start = bus_err_o;
      end
      if (mem_req_o) begin
        obs_req++;
        if (first) begin
          obs_we = mem_we_o; obs_addr = mem_addr_o; obs_sel = mem_sel_o; obs_bwdata = mem_wdata_o;
          first = 1'b0;
        end else if (mem_we_o !== obs_we || mem_addr_o !== obs_addr ||
                     mem_sel_o !== obs_sel || mem_wdata_o !== obs_bwdata) begin
          obs_unstable = 1'b1;
        end
      end
      if (!stallreq_o) begin
        obs_wreg = wreg_o; obs_wdata = wdata_o; obs_wd = wd_o;
        obs_err = bus_err_o; obs_done_req = mem_req_o; obs_hung = 1'b0;
        break;
      end
      obs_stall++;
      @(posedge clk); #1;
      mem_ack_i   = (c == delay);
      mem_rdata_i = (c == delay) ? rd : $urandom;
    end
    @(posedge clk); #1;
    mem_ack_i = 1'b0; aluop_i = OP_NOP; wreg_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0;
    wd_i = 5'h1F; wreg_i = 1'b1; wdata_i = 32'h1000; aluop_i = OP_LW;
    reg2_i = $urandom; mem_rdata_i = $urandom; mem_ack_i = 1'b0;
    #23;
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_req_o); end
    total++; if (mem_we_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_we_o); end
    total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
    total++; if (mem_sel_o !== 4'h0) begin bad++; $display("FAIL reset_sel got=%h exp=0", mem_sel_o); end
    total++; if (mem_wdata_o !== 32'h0) begin bad++; $display("FAIL reset_bwdata got=%h exp=0", mem_wdata_o); end
    total++; if (bus_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus_err_o); end
    total++; if (wd_o !== 5'h0) begin bad++; $display("FAIL reset_wd got=%h exp=0", wd_o); end
    total++; if (wreg_o !== 1'b0) begin bad++; $display("FAIL reset_wreg got=%b exp=0", wreg_o); end
    total++; if (wdata_o !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", wdata_o); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stallreq_o); end
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL reset_misal got=%b exp=0", misalign_o); end
    aluop_i = OP_NOP; wreg_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw;
    run_op(OP_LW, 32'h1000, 32'h0, 5'd3, 1'b1, 0, 32'hDEADBEEF);
    total++; if (obs_hung !== 1'b0) begin bad++; $display("FAIL lw_hung got=%b exp=0", obs_hung); end
    total++; if (obs_sel !== 4'hF) begin bad++; $display("FAIL lw_sel got=%h exp=f", obs_sel); end
    total++; if (obs_addr !== 32'h1000) begin bad++; $display("FAIL lw_addr got=%h exp=00001000", obs_addr); end
    total++; if (obs_we !== 1'b0) begin bad++; $display("FAIL lw_we got=%b exp=0", obs_we); end
    total++; if (obs_stall != 2) begin bad++; $display("FAIL lw_stall got=%0d exp=2", obs_stall); end
    total++; if (obs_req != 1) begin bad++; $display("FAIL lw_req_cycles got=%0d exp=1", obs_req); end
    total++; if (obs_wreg !== 1'b1) begin bad++; $display("FAIL lw_wreg got=%b exp=1", obs_wreg); end
    total++; if (obs_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_wdata got=%h exp=deadbeef", obs_wdata); end
    total++; if (obs_wd !== 5'd3) begin bad++; $display("FAIL lw_wd got=%0d exp=3", obs_wd); end
  endtask

  task automatic test_lb_lbu;
    run_op(OP_LB, 32'h1003, 32'h0, 5'd4, 1'b1, 0, 32'h80123456);
    total++; if (obs_sel !== 4'b1000) begin bad++; $display("FAIL lb_sel got=%b exp=1000", obs_sel); end
    total++; if (obs_wdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_wdata got=%h exp=ffffff80", obs_wdata); end
    run_op(OP_LBU, 32'h1003, 32'h0, 5'd4, 1'b1, 0, 32'h80123456);
    total++; if (obs_wdata !== 32'h00000080) begin bad++; $display("FAIL lbu_wdata got=%h exp=00000080", obs_wdata); end
    total++; if (obs_wreg !== 1'b1) begin bad++; $display("FAIL lbu_wreg got=%b exp=1", obs_wreg); end
  endtask

  task automatic test_sh;
    run_op(OP_SH, 32'h2002, 32'h1234ABCD, 5'd5, 1'b1, 1, 32'h0);
    total++; if (obs_we !== 1'b1) begin bad++; $display("FAIL sh_we got=%b exp=1", obs_we); end
    total++; if (obs_sel !== 4'b1100) begin bad++; $display("FAIL sh_sel got=%b exp=1100", obs_sel); end
    total++; if (obs_bwdata !== 32'hABCDABCD) begin bad++; $display("FAIL sh_bwdata got=%h exp=abcdabcd", obs_bwdata); end
    total++; if (obs_addr !== 32'h2000) begin bad++; $display("FAIL sh_addr got=%h exp=00002000", obs_addr); end
    total++; if (obs_wreg !== 1'b0) begin bad++; $display("FAIL sh_wreg got=%b exp=0", obs_wreg); end
    total++; if (obs_stall != 3) begin bad++; $display("FAIL sh_stall got=%0d exp=3", obs_stall); end
    total++; if (obs_unstable !== 1'b0) begin bad++; $display("FAIL sh_bus_stable got=%b exp=0", obs_unstable); end
  endtask

  task automatic test_misalign;
    run_op(OP_LW, 32'h1001, 32'h0, 5'd6, 1'b1, 0, 32'h12345678);
    total++; if (obs_misal !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b exp=1", obs_misal); end
    total++; if (obs_req != 0) begin bad++; $display("FAIL mis_req got=%0d exp=0", obs_req); end
    total++; if (obs_wreg !== 1'b0) begin bad++; $display("FAIL mis_wreg got=%b exp=0", obs_wreg); end
    total++; if (obs_stall != 0) begin bad++; $display("FAIL mis_stall got=%0d exp=0", obs_stall); end
    run_op(OP_ADD, 32'hCAFE0001, 32'h0, 5'd7, 1'b1, 0, 32'h0);
    total++; if (obs_req_start !== 1'b0) begin bad++; $display("FAIL mis_stayidle got=%b exp=0", obs_req_start); end
    total++; if (obs_wdata !== 32'hCAFE0001) begin bad++; $display("FAIL add_wdata got=%h exp=cafe0001", obs_wdata); end
  endtask

  task automatic test_timeout;
    run_op(OP_LW, 32'h3000, 32'h0, 5'd8, 1'b1, 99, 32'h0);
    total++; if (obs_req != TMO) begin bad++; $display("FAIL to_req_cycles got=%0d exp=%0d", obs_req, TMO); end
    total++; if (obs_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", obs_err); end
    total++; if (obs_wreg !== 1'b0) begin bad++; $display("FAIL to_wreg got=%b exp=0", obs_wreg); end
    total++; if (obs_done_req !== 1'b0) begin bad++; $display("FAIL to_req_done got=%b exp=0", obs_done_req); end
    run_op(OP_LW, 32'h3004, 32'h0, 5'd8, 1'b1, TMO - 1, 32'h55AA55AA);
    total++; if (obs_err_start !== 1'b0) begin bad++; $display("FAIL to_err_pulse got=%b exp=0", obs_err_start); end
    total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL to_ack_wins_err got=%b exp=0", obs_err); end
    total++; if (obs_wdata !== 32'h55AA55AA) begin bad++; $display("FAIL to_ack_wins_data got=%h exp=55aa55aa", obs_wdata); end
  endtask

  task automatic test_reset_in_wait;
    aluop_i = OP_LW; wdata_i = 32'h4000; wd_i = 5'd9; wreg_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL rw_req_before got=%b exp=1", mem_req_o); end
    #2 rst = 1'b0;
    #1;
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rw_req_after got=%b exp=0", mem_req_o); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL rw_stall got=%b exp=0", stallreq_o); end
    total++; if (bus_err_o !== 1'b0) begin bad++; $display("FAIL rw_err got=%b exp=0", bus_err_o); end
    aluop_i = OP_ADD; wdata_i = 32'h0BADF00D; wd_i = 5'd10; wreg_i = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_op(OP_ADD, 32'h0BADF00D, 32'h0, 5'd10, 1'b1, 0, 32'h0);
    total++; if (obs_stall != 0) begin bad++; $display("FAIL rw_add_stall got=%0d exp=0", obs_stall); end
    total++; if (obs_wreg !== 1'b1) begin bad++; $display("FAIL rw_add_wreg got=%b exp=1", obs_wreg); end
    total++; if (obs_wd !== 5'd10) begin bad++; $display("FAIL rw_add_wd got=%0d exp=10", obs_wd); end
  endtask

  task automatic test_back_to_back;
    run_op(OP_SW, 32'h5000, 32'h11223344, 5'd0, 1'b0, 0, 32'h0);
    total++; if (obs_bwdata !== 32'h11223344) begin bad++; $display("FAIL b2b_sw_data got=%h exp=11223344", obs_bwdata); end
    run_op(OP_LHU, 32'h5002, 32'h0, 5'd11, 1'b1, 0, 32'hFEDC1234);
    total++; if (obs_req_start !== 1'b0) begin bad++; $display("FAIL b2b_req_gap got=%b exp=0", obs_req_start); end
    total++; if (obs_wdata !== 32'h0000FEDC) begin bad++; $display("FAIL b2b_lhu got=%h exp=0000fedc", obs_wdata); end
  endtask

  task automatic test_random;
    logic [7:0] ops [9];
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_ADD};
    for (int n = 0; n < 80; n++) begin
      logic [7:0]  op;
      logic [31:0] a, rs2, rd;
      logic [4:0]  wd;
      logic        wr, acc, to, exp_wreg;
      int          sz, dly, exp_req;
      op  = ops[$urandom_range(0, 8)];
      sz  = m_size(op);
      a   = $urandom;
      if (sz != 0 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      rs2 = $urandom; rd = $urandom; wd = 5'($urandom); wr = 1'($urandom);
      dly = $urandom_range(0, 5);
      run_op(op, a, rs2, wd, wr, dly, rd);
      acc      = (sz != 0) && !m_misal(op, a);
      to       = acc && (dly >= TMO);
      exp_req  = acc ? (to ? TMO : dly + 1) : 0;
      exp_wreg = (sz == 0) ? wr : (acc && m_is_load(op) && !to) ? wr : 1'b0;
      total++; if (obs_hung !== 1'b0) begin bad++; $display("FAIL rnd%0d_hung got=%b exp=0", n, obs_hung); end
      total++; if (obs_req != exp_req) begin bad++; $display("FAIL rnd%0d_req op=%h a=%h got=%0d exp=%0d", n, op, a, obs_req, exp_req); end
      total++; if (obs_stall != (acc ? exp_req + 1 : 0)) begin bad++; $display("FAIL rnd%0d_stall got=%0d exp=%0d", n, obs_stall, acc ? exp_req + 1 : 0); end
      total++; if (obs_misal !== 1'(m_misal(op, a))) begin bad++; $display("FAIL rnd%0d_misal got=%b", n, obs_misal); end
      total++; if (obs_wreg !== exp_wreg) begin bad++; $display("FAIL rnd%0d_wreg op=%h got=%b exp=%b", n, op, obs_wreg, exp_wreg); end
      total++; if (obs_err !== to) begin bad++; $display("FAIL rnd%0d_err got=%b exp=%b", n, obs_err, to); end
      total++; if (obs_req_start !== 1'b0 || obs_err_start !== 1'b0) begin bad++; $display("FAIL rnd%0d_idle_entry req=%b err=%b exp=0", n, obs_req_start, obs_err_start); end
      if (sz == 0) begin
        total++; if (obs_wdata !== a) begin bad++; $display("FAIL rnd%0d_pass got=%h exp=%h", n, obs_wdata, a); end
      end
      if (acc) begin
        total++; if (obs_sel !== m_sel(op, a)) begin bad++; $display("FAIL rnd%0d_sel op=%h a=%h got=%h exp=%h", n, op, a, obs_sel, m_sel(op, a)); end
        total++; if (obs_addr !== (a & 32'hFFFF_FFFC)) begin bad++; $display("FAIL rnd%0d_addr got=%h exp=%h", n, obs_addr, a & 32'hFFFF_FFFC); end
        total++; if (obs_we !== !m_is_load(op)) begin bad++; $display("FAIL rnd%0d_we got=%b", n, obs_we); end
        total++; if (obs_unstable !== 1'b0) begin bad++; $display("FAIL rnd%0d_stable got=%b exp=0", n, obs_unstable); end
        if (!m_is_load(op)) begin
          total++; if (obs_bwdata !== m_st(op, rs2)) begin bad++; $display("FAIL rnd%0d_st op=%h got=%h exp=%h", n, op, obs_bwdata, m_st(op, rs2)); end
        end else if (!to) begin
          total++; if (obs_wdata !== m_ld(op, a, rd)) begin bad++; $display("FAIL rnd%0d_ld op=%h a=%h rd=%h got=%h exp=%h", n, op, a, rd, obs_wdata, m_ld(op, a, rd)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_misalign();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage for the RISC-V pipeline. It sits directly downstream of the EX stage, after the EX/MEM pipeline register. Register writes from non-memory ops pass straight through to WB. Loads and stores run as a single-outstanding request/acknowledge transaction on the data bus, and the pipeline is stalled until the transaction completes. The block also does byte-lane steering, load sign/zero extension, misalignment detection and bus-timeout detection.

## Interface
- `ACK_TIMEOUT`, default 255: number of WAIT cycles without `mem_ack_i` before the access is abandoned (range 1..255).
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset. Asserted when 0.
- `wd_i` input 5: destination register address from EX/MEM.
- `wreg_i` input 1: write-enable from EX/MEM.
- `wdata_i` input 32: EX result. For load/store ops this is the effective address.
- `aluop_i` input 8: operation code. The memory ops are `EXE_LB_OP`, `EXE_LH_OP`, `EXE_LW_OP`, `EXE_LBU_OP`, `EXE_LHU_OP`, `EXE_SB_OP`, `EXE_SH_OP` and `EXE_SW_OP`.
- `reg2_i` input 32: store data (rs2).
- `mem_rdata_i` input 32: bus read data. Valid only with `mem_ack_i`.
- `mem_ack_i` input 1: bus acknowledge, one-cycle pulse.
- `mem_req_o` output 1: bus request (registered).
- `mem_we_o` output 1: 1 = write (registered).
- `mem_addr_o` output 32: word-aligned address, `{addr[31:2],2'b00}` (registered).
- `mem_sel_o` output 4: byte-lane enables. Bit n selects byte n, little-endian (registered).
- `mem_wdata_o` output 32: lane-replicated store data (registered).
- `wd_o` output 5: destination register address to WB.
- `wreg_o` output 1: write-enable to WB.
- `wdata_o` output 32: write data to WB.
- `stallreq_o` output 1: stall request to the pipeline controller.
- `misalign_o` output 1: misaligned access detected this cycle.
- `bus_err_o` output 1: access timed out. Registered, one-cycle pulse.

## Operation
- **FSM states:** IDLE, WAIT, DONE.
- **Non-memory op:**
  - `wd_o=wd_i`, `wreg_o=wreg_i`, `wdata_o=wdata_i`, `stallreq_o=0`, combinationally.
  - Only legal in IDLE.
- **Misaligned op:** halfword ops with `addr[0]=1`, or word ops with `addr[1:0]!=0`.
  - No bus access; FSM stays IDLE.
  - `misalign_o=1`, `wreg_o=0`, `stallreq_o=0`.
- **IDLE, aligned memory op present:**
  - `stallreq_o=1`.
  - On the next edge, load the bus registers: `mem_req_o=1`, `mem_we_o`=store, `mem_addr_o`, `mem_sel_o`, `mem_wdata_o`.
  - Clear the timeout counter; go to WAIT.
- **WAIT:**
  - `stallreq_o=1`.
  - Bus registers are held stable; the counter increments every cycle.
  - On `mem_ack_i=1`: capture the formatted load result, drop `mem_req_o`, go to DONE.
  - Else, when the counter reaches `ACK_TIMEOUT-1`: drop `mem_req_o`, set `bus_err_o`, go to DONE.
  - If ack and timeout coincide, ack wins and there is no error.
- **DONE:**
  - `stallreq_o=0`, so the EX/MEM register advances at the end of this cycle.
  - Loads: `wreg_o=wreg_i`, `wdata_o`=captured result.
  - Stores: `wreg_o=0`.
  - A timed-out load forces `wreg_o=0`.
  - `bus_err_o` is cleared on exit. Next state is IDLE unconditionally.
  - The same instruction is still on the inputs during DONE and must not be re-issued.
- **Store lanes:**
  - SB: `sel=4'b0001<<addr[1:0]`, wdata = byte replicated ×4.
  - SH: `sel=4'b0011` or `4'b1100` selected by `addr[1]`, wdata = halfword replicated ×2.
  - SW: `sel=4'b1111`, wdata = `reg2_i`.
- **Load lanes:**
  - Byte n = `mem_rdata_i[8n+7:8n]`; halfword selected by `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes all 32 bits.
  - Loads drive `mem_sel_o` the same way as stores.
- `mem_ack_i` in IDLE or DONE is ignored.
- **Reset, asynchronous:**
  - FSM goes to IDLE; counter and captured data cleared.
  - `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_sel_o`, `mem_wdata_o` and `bus_err_o` go to 0.
  - While `rst=0`: `wd_o=0`, `wreg_o=0`, `wdata_o=0`, `stallreq_o=0`, `misalign_o=0`.
  - Reset in WAIT abandons the access with no error.

## Timing
- **Zero-wait-state access** (ack in the first WAIT cycle): IDLE at cycle 0, WAIT with `req` at cycle 1, DONE at cycle 2.
  - `stallreq_o` is high for cycles 0–1.
  - Total occupancy is 3 cycles; each extra ack-wait cycle adds 1.
- **Timeout:** DONE is entered `ACK_TIMEOUT` cycles after the first WAIT cycle.
- Non-memory ops take 0 extra cycles.
- Back-to-back memory ops:
  - The second op enters IDLE the cycle after DONE.
  - There is a minimum of 1 cycle between `mem_req_o` deassertion and the next assertion.

## Test plan
- LW at 0x1000, ack on the first WAIT cycle with rdata 0xDEADBEEF:
  - `mem_sel_o=4'hF`.
  - `stallreq_o` high for exactly 2 cycles.
  - DONE: `wreg_o=1`, `wdata_o=0xDEADBEEF`.
- LB at 0x1003 with rdata 0x80123456 → `mem_sel_o=4'b1000`, `wdata_o=0xFFFFFF80`. The same access as LBU → `wdata_o=0x00000080`.
- SH at 0x2002 with `reg2_i=0x1234ABCD`:
  - `mem_we_o=1`, `mem_sel_o=4'b1100`, `mem_wdata_o=0xABCDABCD`, `mem_addr_o=0x2000`.
  - `wreg_o=0` in DONE.
- LW at 0x1001 → `misalign_o=1`, `mem_req_o` never asserts, `wreg_o=0`, `stallreq_o=0`.
- With `ACK_TIMEOUT=4`, LW with no ack:
  - `mem_req_o` drops after 4 WAIT cycles.
  - `bus_err_o` is a 1-cycle pulse in DONE; `wreg_o=0`.
- `rst` pulled low during WAIT → `mem_req_o=0` immediately. After release, an ADD passes through with `stallreq_o=0`.
